// File: rtl/exec_datapath.sv
`default_nettype none
// ============================================================================
// Module   : exec_datapath
// Purpose  : Execution-side partner of the control unit. Holds the ALU, a
//            dedicated address adder, a DEPTH-entry data RAM and the output
//            pipeline registers. Results are returned on result2 for the
//            control unit to write back into its register file.
// Ports    : clk       - system clock, rising-edge active
//            rst       - asynchronous, active-high reset
//            operand1  - ALU operand A; base address for loads/stores
//            operand2  - ALU operand B (sel3=0); store data
//            offset    - ALU operand B (sel3=1); address displacement
//            opcode    - ALU operation select (1111 = NOP, registers hold)
//            sel1      - result2 source: 1 = ALU register, 0 = memory read
//            sel3      - ALU B-input select: 1 = offset, 0 = operand2
//            w_r       - data-memory write enable (level, no edge detect)
//            result2   - result returned to the control unit
//            zero      - registered flag: last ALU result was zero
//            carry     - registered carry/borrow flag
// Revision : 1.0 - initial release
// ============================================================================
module exec_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero,
    output logic                  carry
);

    // ------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_NOT  = 4'b0101;
    localparam logic [3:0] c_OP_SHL  = 4'b0110;
    localparam logic [3:0] c_OP_SHR  = 4'b0111;
    localparam logic [3:0] c_OP_PASS = 4'b1000;
    localparam logic [3:0] c_OP_NOP  = 4'b1111;

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_carry;
    logic                  w_alu_zero;
    logic                  w_alu_load;
    logic [ADDR_BITS-1:0]  w_agu_addr;

    logic [DATA_WIDTH-1:0] r_alu_q;
    logic                  r_zero;
    logic                  r_carry;
    logic [DATA_WIDTH-1:0] r_mem_q;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_b = sel3 ? offset : operand2;

    // One extra bit on each arithmetic path: bit DATA_WIDTH of the sum is
    // the carry-out, and bit DATA_WIDTH of the zero-extended difference is
    // set exactly when A < B, i.e. the borrow.
    assign w_sum  = {1'b0, operand1} + {1'b0, w_b};
    assign w_diff = {1'b0, operand1} - {1'b0, w_b};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (opcode)
            c_OP_ADD: begin
                w_alu_res   = w_sum[DATA_WIDTH-1:0];
                w_alu_carry = w_sum[DATA_WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res   = w_diff[DATA_WIDTH-1:0];
                w_alu_carry = w_diff[DATA_WIDTH];
            end
            c_OP_AND:  w_alu_res = operand1 & w_b;
            c_OP_OR:   w_alu_res = operand1 | w_b;
            c_OP_XOR:  w_alu_res = operand1 ^ w_b;
            c_OP_NOT:  w_alu_res = ~operand1;
            c_OP_SHL: begin
                w_alu_res   = {operand1[DATA_WIDTH-2:0], 1'b0};
                w_alu_carry = operand1[DATA_WIDTH-1];
            end
            c_OP_SHR: begin
                w_alu_res   = {1'b0, operand1[DATA_WIDTH-1:1]};
                w_alu_carry = operand1[0];
            end
            c_OP_PASS: w_alu_res = w_b;
            default: begin
                w_alu_res   = '0;
                w_alu_carry = 1'b0;
            end
        endcase
    end

    assign w_alu_zero = (w_alu_res == '0);

    // NOP leaves the ALU result and both flags untouched so a value
    // computed earlier survives idle control-unit states.
    assign w_alu_load = (opcode != c_OP_NOP);

    // ------------------------------------------------------------------
    // ALU output register and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_q <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_alu_load) begin
            r_alu_q <= w_alu_res;
            r_zero  <= w_alu_zero;
            r_carry <= w_alu_carry;
        end
    end

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    // Only the low ADDR_BITS of operand1 + offset matter, so the adder is
    // built at address width and wraps modulo DEPTH by construction. It is
    // independent of sel3 and opcode.
    assign w_agu_addr = operand1[ADDR_BITS-1:0] + offset[ADDR_BITS-1:0];

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    // Reset reloads every word with its own index. The read register takes
    // the pre-write contents on a same-address collision (read-before-write)
    // because both updates are non-blocking on the same edge. Stores held
    // across several cycles simply rewrite the same word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_WIDTH'(i);
            end
        end else begin
            r_mem_q <= r_mem[w_agu_addr];
            if (w_r) begin
                r_mem[w_agu_addr] <= operand2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: mux of registered sources only
    // ------------------------------------------------------------------
    assign result2 = sel1 ? r_alu_q : r_mem_q;
    assign zero    = r_zero;
    assign carry   = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_exec_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_datapath
// Purpose  : Self-checking bench for exec_datapath: reset state, a table of
//            ALU vectors, hand-written memory/collision/reset sequences and
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [7:0] offset;
    logic [3:0] opcode;
    logic       sel1;
    logic       sel3;
    logic       w_r;
    logic [7:0] result2;
    logic       zero;
    logic       carry;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_mem [32];
    int m_alu;
    bit m_zero;
    bit m_carry;
    int m_memq;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] off;
        logic [3:0] opc;
        logic       s1;
        logic       s3;
        logic [7:0] er;
        logic       ez;
        logic       ec;
    } vec_t;

    vec_t vecs [15];

    exec_datapath #(
        .DATA_WIDTH (8),
        .ADDR_BITS  (5),
        .DEPTH      (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .operand1 (operand1),
        .operand2 (operand2),
        .offset   (offset),
        .opcode   (opcode),
        .sel1     (sel1),
        .sel3     (sel3),
        .w_r      (w_r),
        .result2  (result2),
        .zero     (zero),
        .carry    (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Reference ALU computed from the operation definitions with integers.
    task automatic ref_alu(input int op, input int a, input int b, output int res, output bit cy);
        cy  = 1'b0;
        res = 0;
        case (op)
            0: begin res = a + b; cy = (res > 255); res = res % 256; end
            1: begin cy = (a < b); res = (a - b + 256) % 256; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin cy = (a >= 128); res = (a * 2) % 256; end
            7: begin cy = (a % 2 == 1); res = a / 2; end
            8: res = b;
            default: res = 0;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = i;
        m_alu   = 0;
        m_zero  = 1'b0;
        m_carry = 1'b0;
        m_memq  = 0;
    endtask

    // Advance the model with the current inputs, then take one clock edge
    // and land 1 time unit after it.
    task automatic step();
        int res;
        bit cy;
        int addr;
        int b;
        b    = sel3 ? int'(offset) : int'(operand2);
        addr = (int'(operand1) + int'(offset)) % 32;
        if (opcode != 4'hF) begin
            ref_alu(int'(opcode), int'(operand1), b, res, cy);
            m_alu   = res;
            m_zero  = (res == 0);
            m_carry = cy;
        end
        m_memq = m_mem[addr];
        if (w_r) m_mem[addr] = int'(operand2);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                          input logic [3:0] op, input logic s1, input logic s3, input logic wr);
        operand1 = a;
        operand2 = b;
        offset   = o;
        opcode   = op;
        sel1     = s1;
        sel3     = s3;
        w_r      = wr;
    endtask

    initial begin
        logic [7:0] exp_r;

        //            op1    op2    off    opc   s1    s3    res    z     c
        vecs[0]  = '{8'h02, 8'h03, 8'h00, 4'h0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{8'h01, 8'hFF, 8'h02, 4'h0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3]  = '{8'h03, 8'h05, 8'h00, 4'h1, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[4]  = '{8'h05, 8'h05, 8'h00, 4'h1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'hF0, 8'h3C, 8'h00, 4'h2, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6]  = '{8'hF0, 8'h0F, 8'h00, 4'h3, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'hAA, 8'hAA, 8'h00, 4'h4, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{8'h0F, 8'h00, 8'h00, 4'h5, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[9]  = '{8'h81, 8'h00, 8'h00, 4'h6, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1};
        vecs[10] = '{8'h81, 8'h00, 8'h00, 4'h7, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1};
        vecs[11] = '{8'h12, 8'h34, 8'h7E, 4'h8, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[12] = '{8'h55, 8'h33, 8'h00, 4'h9, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'h10, 8'h00, 8'h20, 4'h0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0};
        vecs[14] = '{8'h99, 8'h99, 8'h99, 4'hF, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0};

        // ---------------- Reset and idle ----------------
        rst = 1'b1;
        set_in(8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        chk("reset_result2", result2, 8'h00);
        chk("reset_zero", {7'b0, zero}, 8'h00);
        chk("reset_carry", {7'b0, carry}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_result2", result2, 8'h00);
        set_in(8'h05, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        chk("mem5_after_reset", result2, 8'h05);

        // ---------------- ALU table ----------------
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].op1, vecs[i].op2, vecs[i].off, vecs[i].opc,
                   vecs[i].s1, vecs[i].s3, 1'b0);
            step();
            chk($sformatf("vec%0d_result", i), result2, vecs[i].er);
            chk($sformatf("vec%0d_zero", i), {7'b0, zero}, {7'b0, vecs[i].ez});
            chk($sformatf("vec%0d_carry", i), {7'b0, carry}, {7'b0, vecs[i].ec});
        end

        // ---------------- NOP hold after overflow ----------------
        set_in(8'hFF, 8'h01, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(8'h44, 8'h22, 8'h11, 4'hF, 1'b1, 1'b0, 1'b0);
            step();
            chk("nop_hold_result", result2, 8'h00);
            chk("nop_hold_zero", {7'b0, zero}, 8'h01);
            chk("nop_hold_carry", {7'b0, carry}, 8'h01);
        end

        // ---------------- Store held 3 cycles, then load ----------------
        set_in(8'h01, 8'hAA, 8'h04, 4'hF, 1'b0, 1'b1, 1'b1);
        step();
        chk("store_first_read_old", result2, 8'h05);
        step();
        step();
        set_in(8'h01, 8'h00, 8'h04, 4'hF, 1'b0, 1'b1, 1'b0);
        step();
        chk("load_after_store", result2, 8'hAA);

        // ---------------- Address wrap ----------------
        set_in(8'h1F, 8'h00, 8'h02, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        chk("wrap_read", result2, 8'h01);
        set_in(8'h1F, 8'h55, 8'h02, 4'hF, 1'b0, 1'b0, 1'b1);
        step();
        set_in(8'h01, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        chk("wrap_store_at_1", result2, 8'h55);

        // ---------------- Read/write collision ----------------
        set_in(8'h07, 8'h3C, 8'h00, 4'hF, 1'b0, 1'b0, 1'b1);
        step();
        chk("collision_old", result2, 8'h07);
        step();
        chk("collision_new", result2, 8'h3C);

        // ---------------- Reset mid-store ----------------
        set_in(8'h20, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("pre_reset_alu", result2, 8'h20);
        set_in(8'h09, 8'hEE, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_result2", result2, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_in(8'h09, 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        chk("after_reset_mem9", result2, 8'h09);
        chk("after_reset_zero", {7'b0, zero}, 8'h00);
        chk("after_reset_carry", {7'b0, carry}, 8'h00);

        // ---------------- Randomized traffic vs model ----------------
        for (int n = 0; n < 400; n++) begin
            set_in(8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            step();
            exp_r = sel1 ? 8'(m_alu) : 8'(m_memq);
            chk($sformatf("rand%0d_result", n), result2, exp_r);
            chk($sformatf("rand%0d_zero", n), {7'b0, zero}, {7'b0, m_zero});
            chk($sformatf("rand%0d_carry", n), {7'b0, carry}, {7'b0, m_carry});
        end

        // Sweep every address once to catch any stray memory corruption.
        for (int a = 0; a < 32; a++) begin
            set_in(8'(a), 8'h00, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("sweep%0d", a), result2, 8'(m_memq));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
